dds_phase_gen: RTL and testbench

Phase accumulator and quarter-wave address generator for the DDS path. It sits directly upstream of the reprogrammable sine LUT and drives that LUT's read enable and read address. It takes back the LUT's unsigned magnitude and rebuilds a full-period signed sample using the quadrant bits. Frequency is set by a double-buffered tuning word, which is applied on accumulator wrap so that retuning is phase-continuous.

---
 rtl/dds_phase_gen.sv | 133 +++++++++++++
 tb/tb_dds_phase_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_gen.sv
// Phase accumulator with quarter-wave LUT addressing and signed sample rebuild.
// The tuning word is double-buffered and applied on accumulator wrap so retuning keeps phase continuous.
module dds_phase_gen #(
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              phase_clr,
  input  logic              ftw_wr,
  input  logic [ACC_W-1:0]  ftw_in,
  output logic              lut_re,
  output logic [ADDR_W-1:0] lut_ra,
  input  logic [DATA_W-1:0] lut_rd,
  output logic [DATA_W:0]   sample_out,
  output logic              sample_valid,
  output logic              wrap
);

  // Valid semantics (no backpressure): lut_re high means lut_ra is a real
  // request and lut_rd carries its data one cycle later; sample_valid high
  // marks sample_out as a new sample for exactly that cycle.

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  ftw_act_q, ftw_act_d;
  logic [ACC_W-1:0]  ftw_shd_q, ftw_shd_d;
  logic              shd_pend_q, shd_pend_d;
  logic              lut_re_q, lut_re_d;
  logic [ADDR_W-1:0] lut_ra_q, lut_ra_d;
  logic              wrap_q, wrap_d;
  logic              sign1_q, sign1_d;
  logic              vld2_q, vld2_d;
  logic              sign2_q, sign2_d;
  logic [DATA_W:0]   sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;

  logic [ACC_W:0]    sum;
  logic              carry;
  logic [1:0]        quad;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] fold_addr;
  logic [DATA_W:0]   mag;

  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, ftw_act_q};
    carry     = en & sum[ACC_W];
    quad      = acc_q[ACC_W-1 -: 2];
    idx       = acc_q[ACC_W-3 -: ADDR_W];
    // Odd quadrants walk the quarter wave backwards.
    fold_addr = quad[0] ? ~idx : idx;
    mag       = {1'b0, lut_rd};

    acc_d          = acc_q;
    ftw_act_d      = ftw_act_q;
    ftw_shd_d      = ftw_shd_q;
    shd_pend_d     = shd_pend_q;
    lut_re_d       = en;
    lut_ra_d       = lut_ra_q;
    wrap_d         = carry;
    sign1_d        = sign1_q;
    vld2_d         = lut_re_q;
    sign2_d        = sign1_q;
    sample_d       = sample_q;
    sample_valid_d = vld2_q;

    if (en) begin
      acc_d    = sum[ACC_W-1:0];
      lut_ra_d = fold_addr;
      sign1_d  = quad[1];
    end
    if (phase_clr) begin
      acc_d = '0;
    end

    if (vld2_q) begin
      sample_d = sign2_q ? -mag : mag;
    end

    if (ftw_wr) begin
      ftw_shd_d = ftw_in;
      if (en) begin
        shd_pend_d = 1'b1;
      end else begin
        ftw_act_d  = ftw_in;
        shd_pend_d = 1'b0;
      end
    end
    // A write landing on the wrap edge itself is the newest word, so it wins.
    if (carry && (shd_pend_q || ftw_wr)) begin
      ftw_act_d  = ftw_wr ? ftw_in : ftw_shd_q;
      shd_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q          <= '0;
      ftw_act_q      <= '0;
      ftw_shd_q      <= '0;
      shd_pend_q     <= 1'b0;
      lut_re_q       <= 1'b0;
      lut_ra_q       <= '0;
      wrap_q         <= 1'b0;
      sign1_q        <= 1'b0;
      vld2_q         <= 1'b0;
      sign2_q        <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      ftw_act_q      <= ftw_act_d;
      ftw_shd_q      <= ftw_shd_d;
      shd_pend_q     <= shd_pend_d;
      lut_re_q       <= lut_re_d;
      lut_ra_q       <= lut_ra_d;
      wrap_q         <= wrap_d;
      sign1_q        <= sign1_d;
      vld2_q         <= vld2_d;
      sign2_q        <= sign2_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign lut_re       = lut_re_q;
  assign lut_ra       = lut_ra_q;
  assign wrap         = wrap_q;
  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen with a registered sine-LUT model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        phase_clr = 1'b0;
  logic        ftw_wr = 1'b0;
  logic [15:0] ftw_in = '0;
  logic        lut_re;
  logic [3:0]  lut_ra;
  logic [5:0]  lut_rd = '0;
  logic [6:0]  sample_out;
  logic        sample_valid;
  logic        wrap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dds_phase_gen #(.ACC_W(16), .ADDR_W(4), .DATA_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .phase_clr    (phase_clr),
    .ftw_wr       (ftw_wr),
    .ftw_in       (ftw_in),
    .lut_re       (lut_re),
    .lut_ra       (lut_ra),
    .lut_rd       (lut_rd),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  function automatic logic [5:0] lut_f(input logic [3:0] a);
    return (a <= 4'd5) ? 6'(int'(a) * 10) : 6'd50;
  endfunction

  function automatic logic [3:0] fold_f(input logic [15:0] a);
    logic [3:0] i;
    i = a[13:10];
    return a[14] ? ~i : i;
  endfunction

  function automatic logic [6:0] samp_f(input logic [15:0] a);
    logic [6:0] m;
    m = {1'b0, lut_f(fold_f(a))};
    return a[15] ? -m : m;
  endfunction

  // Phase used at edge j: 0x0400 steps through the wrap at edge 64, then 0x0C00.
  function automatic logic [15:0] retune_ph(input int j);
    return (j <= 65) ? 16'((j - 1) * 32'h0400) : 16'((j - 65) * 32'h0C00);
  endfunction

  // Phase used at edge j: 0x1000 steps, cleared on edge 6.
  function automatic logic [15:0] clr_ph(input int j);
    return (j <= 6) ? 16'((j - 1) * 32'h1000) : 16'((j - 7) * 32'h1000);
  endfunction

  always @(posedge clk) begin
    if (lut_re) lut_rd <= lut_f(lut_ra);
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; en = 1'b0; phase_clr = 1'b0; ftw_wr = 1'b0; ftw_in = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_ftw(input logic [15:0] v);
    ftw_wr = 1'b1; ftw_in = v;
    @(negedge clk);
    ftw_wr = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++; if (lut_re !== 1'b0) begin n_fail++; $display("FAIL reset_lut_re: got %0b want 0", lut_re); end
    n_checks++; if (lut_ra !== 4'd0) begin n_fail++; $display("FAIL reset_lut_ra: got %0d want 0", lut_ra); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %0b want 0", wrap); end
    n_checks++; if (sample_out !== 7'd0) begin n_fail++; $display("FAIL reset_sample_out: got %0h want 0", sample_out); end
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sample_valid: got %0b want 0", sample_valid); end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      n_checks++; if (lut_re !== 1'b0) begin n_fail++; $display("FAIL idle_lut_re c%0d: got %0b want 0", n, lut_re); end
      n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid c%0d: got %0b want 0", n, sample_valid); end
    end
  endtask

  task automatic test_coarse;
    logic [3:0]  exp_ra [16];
    logic [15:0] ph;
    logic        exp_w;
    exp_ra = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd15, 4'd11, 4'd7, 4'd3,
               4'd0, 4'd4, 4'd8, 4'd12, 4'd15, 4'd11, 4'd7, 4'd3};
    do_reset();
    load_ftw(16'h1000);
    en = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      exp_w = (n == 16);
      if (n <= 16) begin
        n_checks++; if (lut_re !== 1'b1) begin n_fail++; $display("FAIL coarse_lut_re e%0d: got %0b want 1", n, lut_re); end
        n_checks++; if (lut_ra !== exp_ra[n-1]) begin n_fail++; $display("FAIL coarse_lut_ra e%0d: got %0d want %0d", n, lut_ra, exp_ra[n-1]); end
        n_checks++; if (wrap !== exp_w) begin n_fail++; $display("FAIL coarse_wrap e%0d: got %0b want %0b", n, wrap, exp_w); end
      end else begin
        n_checks++; if (lut_re !== 1'b0) begin n_fail++; $display("FAIL coarse_stop_re e%0d: got %0b want 0", n, lut_re); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL coarse_stop_wrap e%0d: got %0b want 0", n, wrap); end
      end
      if (n >= 3 && n <= 18) begin
        ph = 16'((n - 3) * 32'h1000);
        n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL coarse_valid e%0d: got %0b want 1", n, sample_valid); end
        n_checks++; if (sample_out !== samp_f(ph)) begin n_fail++; $display("FAIL coarse_sample e%0d: got %0h want %0h", n, sample_out, samp_f(ph)); end
      end else begin
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL coarse_novalid e%0d: got %0b want 0", n, sample_valid); end
      end
      if (n == 19) begin
        n_checks++; if (sample_out !== 7'h62) begin n_fail++; $display("FAIL coarse_hold e%0d: got %0h want 62", n, sample_out); end
      end
      if (n == 16) en = 1'b0;
    end
  endtask

  task automatic test_samples;
    logic [15:0] ph;
    do_reset();
    load_ftw(16'h0400);
    en = 1'b1;
    for (int n = 1; n <= 66; n++) begin
      @(negedge clk);
      if (n <= 64) begin
        ph = 16'((n - 1) * 32'h0400);
        n_checks++; if (lut_ra !== fold_f(ph)) begin n_fail++; $display("FAIL samp_lut_ra e%0d: got %0d want %0d", n, lut_ra, fold_f(ph)); end
      end
      if (n >= 3) begin
        ph = 16'((n - 3) * 32'h0400);
        n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL samp_valid e%0d: got %0b want 1", n, sample_valid); end
        n_checks++; if (sample_out !== samp_f(ph)) begin n_fail++; $display("FAIL samp_value e%0d: got %0h want %0h", n, sample_out, samp_f(ph)); end
      end
      if (n == 38) begin
        n_checks++; if (sample_out !== 7'h62) begin n_fail++; $display("FAIL samp_q2_addr3 e%0d: got %0h want 62 (-30)", n, sample_out); end
      end
      if (n == 64) en = 1'b0;
    end
  endtask

  task automatic test_retune;
    logic exp_w;
    do_reset();
    load_ftw(16'h0400);
    en = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      exp_w = (n == 64);
      n_checks++; if (lut_ra !== fold_f(retune_ph(n))) begin n_fail++; $display("FAIL retune_lut_ra e%0d: got %0d want %0d", n, lut_ra, fold_f(retune_ph(n))); end
      n_checks++; if (wrap !== exp_w) begin n_fail++; $display("FAIL retune_wrap e%0d: got %0b want %0b", n, wrap, exp_w); end
      if (n >= 3) begin
        n_checks++; if (sample_out !== samp_f(retune_ph(n - 2))) begin n_fail++; $display("FAIL retune_sample e%0d: got %0h want %0h", n, sample_out, samp_f(retune_ph(n - 2))); end
      end
      ftw_wr = (n == 10) || (n == 20);
      ftw_in = (n == 10) ? 16'h0800 : 16'h0C00;
      if (n == 70) en = 1'b0;
    end
    ftw_wr = 1'b0;
  endtask

  task automatic test_phase_clr;
    do_reset();
    load_ftw(16'h1000);
    en = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      n_checks++; if (lut_ra !== fold_f(clr_ph(n))) begin n_fail++; $display("FAIL clr_lut_ra e%0d: got %0d want %0d", n, lut_ra, fold_f(clr_ph(n))); end
      if (n >= 3) begin
        n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL clr_valid e%0d: got %0b want 1", n, sample_valid); end
        n_checks++; if (sample_out !== samp_f(clr_ph(n - 2))) begin n_fail++; $display("FAIL clr_sample e%0d: got %0h want %0h", n, sample_out, samp_f(clr_ph(n - 2))); end
      end
      if (n == 8) begin
        n_checks++; if (sample_out !== 7'd50) begin n_fail++; $display("FAIL clr_inflight e%0d: got %0h want 32", n, sample_out); end
      end
      if (n == 10) begin
        n_checks++; if (sample_out !== 7'd40) begin n_fail++; $display("FAIL clr_pos_sign e%0d: got %0h want 28", n, sample_out); end
      end
      phase_clr = (n == 5);
      if (n == 10) en = 1'b0;
    end
    phase_clr = 1'b0;
  endtask

  task automatic test_mid_reset;
    logic exp_v;
    do_reset();
    load_ftw(16'h1000);
    en = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %0b want 0", sample_valid); end
    n_checks++; if (lut_re !== 1'b0) begin n_fail++; $display("FAIL mrst_lut_re: got %0b want 0", lut_re); end
    n_checks++; if (lut_ra !== 4'd0) begin n_fail++; $display("FAIL mrst_lut_ra: got %0d want 0", lut_ra); end
    n_checks++; if (sample_out !== 7'd0) begin n_fail++; $display("FAIL mrst_sample: got %0h want 0", sample_out); end
    rst = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      exp_v = (n >= 3);
      n_checks++; if (lut_re !== 1'b1) begin n_fail++; $display("FAIL mrst_re e%0d: got %0b want 1", n, lut_re); end
      n_checks++; if (lut_ra !== 4'd0) begin n_fail++; $display("FAIL mrst_ra e%0d: got %0d want 0", n, lut_ra); end
      n_checks++; if (sample_valid !== exp_v) begin n_fail++; $display("FAIL mrst_valid e%0d: got %0b want %0b", n, sample_valid, exp_v); end
      if (n >= 3) begin
        n_checks++; if (sample_out !== 7'd0) begin n_fail++; $display("FAIL mrst_sample e%0d: got %0h want 0", n, sample_out); end
      end
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_coarse();
    test_samples();
    test_retune();
    test_phase_clr();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
